// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
//   Pipeline hazard unit for the RV32I core. It follows the instructions that
//   have left EX through N_FWD downstream stages (stage 1 = EX/MEM, stage
//   N_FWD = writeback). From that history and the instruction now entering EX
//   it produces the operand forwarding selects, the load-use stall and the
//   branch/jump flush.
//
// Parameters
//   N_FWD       downstream stages tracked for forwarding (1..4)
//   LOAD_STALL  bubble cycles inserted on a load-use hazard (1..3)
//   BR_FLUSH    cycles flush is held after a redirect (1..3)
//   SELW        width of the forward selects (derived)
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   inst_i       instruction entering EX
//   inst_valid_i inst_i is a real instruction
//   redirect_i   EX resolved a taken branch/jump this cycle
//   stall_o      hold PC and decode register, bubble into EX
//   flush_o      squash the younger decode/fetch slots
//   fwd_a_sel_o  rs1 source: 0 = regfile, k = stage-k result
//   fwd_b_sel_o  rs2 source, same encoding
//   mem_we_o     stage-1 instruction is a valid store
//   reg_w_en_o   stage-N_FWD instruction writes a non-zero rd
module hazard_fwd_ctrl #(
    parameter int N_FWD      = 2,
    parameter int LOAD_STALL = 1,
    parameter int BR_FLUSH   = 2,
    localparam int SELW      = $clog2(N_FWD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_i,
    input  logic            inst_valid_i,
    input  logic            redirect_i,
    output logic            stall_o,
    output logic            flush_o,
    output logic [SELW-1:0] fwd_a_sel_o,
    output logic [SELW-1:0] fwd_b_sel_o,
    output logic            mem_we_o,
    output logic            reg_w_en_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REGREG = 7'b0110011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STALL,
        S_FLUSH
    } state_t;

    state_t state, state_nxt;
    logic [1:0] cnt, cnt_nxt;

    // Index i holds pipeline stage i+1. A stage only needs to remember whether
    // it will write a register and which one; the writer bit doubles as the
    // valid bit because bubbles never write.
    logic [N_FWD-1:0] stg_wr;
    logic [4:0]       stg_rd [N_FWD];
    logic             ld1;
    logic             st1;

    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       rs1_used, rs2_used, in_writer;
    logic       eff_valid, hazard, accept;
    logic       stall, flush;

    assign op  = inst_i[6:0];
    assign rd  = inst_i[11:7];
    assign rs1 = inst_i[19:15];
    assign rs2 = inst_i[24:20];

    assign rs1_used  = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    assign rs2_used  = (op == OP_REGREG || op == OP_STORE || op == OP_BRANCH);
    assign in_writer = (op != OP_STORE) && (op != OP_BRANCH) && (op != 7'd0) && (rd != 5'd0);

    // While a flush is running the decode slot holds squashed work, so EX sees
    // a bubble. The redirecting instruction itself is always real.
    assign eff_valid = inst_valid_i && (redirect_i || state != S_FLUSH);

    // A load in stage 1 has no data yet; any consumer must wait.
    assign hazard = eff_valid && ld1 && stg_wr[0] && !redirect_i &&
                    ((rs1_used && rs1 != 5'd0 && rs1 == stg_rd[0]) ||
                     (rs2_used && rs2 != 5'd0 && rs2 == stg_rd[0]));

    // Next state and stall/flush. A redirect wins over everything, which also
    // cancels a stall in progress and restarts a flush already running.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        flush     = 1'b0;
        if (redirect_i) begin
            flush = 1'b1;
            if (BR_FLUSH > 1) begin
                state_nxt = S_FLUSH;
                cnt_nxt   = 2'(BR_FLUSH - 1);
            end else begin
                state_nxt = S_IDLE;
                cnt_nxt   = 2'd0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (hazard) begin
                        stall = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_nxt = S_STALL;
                            cnt_nxt   = 2'(LOAD_STALL - 1);
                        end
                    end
                end
                S_STALL, S_FLUSH: begin
                    stall = (state == S_STALL);
                    flush = (state == S_FLUSH);
                    if (cnt <= 2'd1) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 2'd0;
                    end else begin
                        cnt_nxt = cnt - 2'd1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    assign accept = eff_valid && !stall;

    // State register and stage tracker; stage 1 takes the accepted EX
    // instruction or a bubble, older stages shift down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 2'd0;
            stg_wr <= '0;
            ld1    <= 1'b0;
            st1    <= 1'b0;
            for (int k = 0; k < N_FWD; k++) begin
                stg_rd[k] <= 5'd0;
            end
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            stg_wr[0] <= accept && in_writer;
            stg_rd[0] <= rd;
            ld1       <= accept && (op == OP_LOAD);
            st1       <= accept && (op == OP_STORE);
            for (int k = 1; k < N_FWD; k++) begin
                stg_wr[k] <= stg_wr[k-1];
                stg_rd[k] <= stg_rd[k-1];
            end
        end
    end

    // Nearest matching writer wins, so scan from oldest to youngest. A load
    // still in stage 1 cannot supply data and masks any older match.
    always_comb begin
        fwd_a_sel_o = '0;
        fwd_b_sel_o = '0;
        for (int k = N_FWD - 1; k >= 0; k--) begin
            if (stg_wr[k] && stg_rd[k] == rs1) begin
                fwd_a_sel_o = (k == 0 && ld1) ? '0 : SELW'(k + 1);
            end
            if (stg_wr[k] && stg_rd[k] == rs2) begin
                fwd_b_sel_o = (k == 0 && ld1) ? '0 : SELW'(k + 1);
            end
        end
        if (!rs1_used || rs1 == 5'd0) begin
            fwd_a_sel_o = '0;
        end
        if (!rs2_used || rs2 == 5'd0) begin
            fwd_b_sel_o = '0;
        end
    end

    assign stall_o    = stall;
    assign flush_o    = flush;
    assign mem_we_o   = st1;
    assign reg_w_en_o = stg_wr[N_FWD-1];

endmodule
